// File: rtl/dmem_bridge.sv
`timescale 1ns/1ps
// dmem_bridge: bridges the core data-memory port onto a single-outstanding
// request/acknowledge bus. Stores are posted through a one-entry write buffer,
// loads that hit the buffered word are forwarded without a bus access, and
// every bus transaction is bounded by a timeout that aborts it with bus_err.
module dmem_bridge #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err,
    output logic        wbuf_full
);

    localparam int          CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [31:0] RD_POISON = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WDRAIN = 2'd1,
        RD     = 2'd2,
        RDONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              wb_valid;
    logic [29:0]       wb_addr;
    logic [31:0]       wb_data;
    logic [31:0]       rdata_q;
    logic [CNT_W-1:0]  tmo_cnt;

    logic              is_store;
    logic              is_load;
    logic              ld_hit;
    logic              ack_v;
    logic              tmo_hit;
    logic              st_accept;
    logic              rd_start;
    logic              stall_c;

    // Byte offset is irrelevant for word accesses.
    logic              unused_addr_lsb;
    assign unused_addr_lsb = ^mem_addr[1:0];

    // Simultaneous load and store requests are handled as a store.
    assign is_store = mem_wen;
    assign is_load  = mem_ren & ~mem_wen;
    assign ld_hit   = is_load & wb_valid & (wb_addr == mem_addr[31:2]);

    // An acknowledge only counts while a request is outstanding.
    assign ack_v    = bus_ack & bus_req;
    // Abort fires on the cycle the counter would reach TIMEOUT; an ack in that
    // same cycle wins and completes the transfer normally.
    assign tmo_hit  = bus_req & ~bus_ack & (tmo_cnt == CNT_W'(TIMEOUT - 1));

    assign wbuf_full = wb_valid;
    assign mem_din   = ld_hit ? wb_data : rdata_q;
    // While reset is asserted the core is never held.
    assign mem_stall = rst & stall_c;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, request launch and core stall decode.
    always_comb begin
        state_nxt = state;
        st_accept = 1'b0;
        rd_start  = 1'b0;
        stall_c   = 1'b0;
        case (state)
            IDLE: begin
                if (is_store) begin
                    st_accept = 1'b1;
                    state_nxt = WDRAIN;
                end else if (is_load && !ld_hit) begin
                    stall_c   = 1'b1;
                    rd_start  = 1'b1;
                    state_nxt = RD;
                end
            end
            WDRAIN: begin
                // Buffer is occupied: a new store or a missing load must wait.
                stall_c = is_store | (is_load & ~ld_hit);
                if (ack_v || tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            RD: begin
                stall_c = mem_ren | mem_wen;
                if (ack_v || tmo_hit) begin
                    state_nxt = RDONE;
                end
            end
            RDONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Write buffer valid flag: set on store acceptance, cleared when drained or aborted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid <= 1'b0;
        end else if (st_accept) begin
            wb_valid <= 1'b1;
        end else if (state == WDRAIN && (ack_v || tmo_hit)) begin
            wb_valid <= 1'b0;
        end
    end

    // Write buffer payload; only meaningful while wb_valid is set.
    always_ff @(posedge clk) begin
        if (st_accept) begin
            wb_addr <= mem_addr[31:2];
            wb_data <= mem_dout;
        end
    end

    // Bus request channel, timeout counter and abort pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_err   <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            bus_err <= tmo_hit;
            if (st_accept || rd_start) begin
                bus_req  <= 1'b1;
                bus_we   <= st_accept;
                bus_addr <= {mem_addr[31:2], 2'b00};
                tmo_cnt  <= '0;
                if (st_accept) begin
                    bus_wdata <= mem_dout;
                end
            end else if (bus_req) begin
                if (ack_v || tmo_hit) begin
                    bus_req <= 1'b0;
                end
                if (!bus_ack) begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Load return register: bus data on completion, poison value on abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (state == RD) begin
            if (ack_v) begin
                rdata_q <= bus_rdata;
            end else if (tmo_hit) begin
                rdata_q <= RD_POISON;
            end
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
`timescale 1ns/1ps
// tb_dmem_bridge: drives the bridge as a core and as a bus slave, and checks
// it every cycle against a transaction-level reference of the bridge.
module tb_dmem_bridge;

    localparam int TIMEOUT = 64;

    logic        clk;
    logic        rst;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic        wbuf_full;

    dmem_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .mem_stall (mem_stall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .bus_err   (bus_err),
        .wbuf_full (wbuf_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;

    // Slave side
    logic [31:0] smem [0:63];
    logic [31:0] wlog_a [$];
    logic [31:0] wlog_d [$];
    int          rd_acks = 0;
    int          ack_delay = 0;
    logic        stray_ack = 1'b0;
    int          slv_wait = 0;

    // Reference model of the bridge at transaction level
    logic        m_buf_v;
    logic [29:0] m_buf_a;
    logic [31:0] m_buf_d;
    logic        m_txn;
    logic        m_txn_we;
    logic [31:0] m_txn_a;
    logic [31:0] m_txn_d;
    int          m_age;
    logic        m_rd_ready;
    logic [31:0] m_rdata;
    logic        m_err;

    function automatic logic [31:0] init_word(int i);
        return (i == 4) ? 32'h12345678 : (32'hC0DE0000 | 32'(i));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Bus slave: acks after ack_delay cycles of request, keeps a memory and a write log.
    initial begin
        bus_ack   = 1'b0;
        bus_rdata = '0;
        for (int i = 0; i < 64; i++) smem[i] = init_word(i);
        forever begin
            @(posedge clk);
            #1;
            if (stray_ack) begin
                bus_ack   = 1'b1;
                bus_rdata = 32'hBAD0BAD0;
                slv_wait  = 0;
            end else if (!rst || !bus_req) begin
                bus_ack  = 1'b0;
                slv_wait = 0;
            end else if (slv_wait == ack_delay) begin
                bus_ack  = 1'b1;
                slv_wait = 0;
                if (bus_we) begin
                    smem[bus_addr[7:2]] = bus_wdata;
                    wlog_a.push_back(bus_addr);
                    wlog_d.push_back(bus_wdata);
                end else begin
                    bus_rdata = smem[bus_addr[7:2]];
                    rd_acks++;
                end
            end else begin
                bus_ack = 1'b0;
                slv_wait++;
            end
        end
    end

    task automatic model_launch(input logic we, input logic [31:0] a, input logic [31:0] d);
        m_txn    = 1'b1;
        m_txn_we = we;
        m_txn_a  = {a[31:2], 2'b00};
        m_txn_d  = d;
        m_age    = 0;
    endtask

    // Per-cycle comparison against the reference, then advance the reference.
    task automatic compare_loop();
        logic is_st, is_ld, hit, acc, e_stall, nrr;
        forever begin
            @(negedge clk);
            if (bus_err === 1'b1) err_cnt++;
            if (!rst) begin
                chk("rst_bus_req",   32'(bus_req),   32'd0);
                chk("rst_bus_we",    32'(bus_we),    32'd0);
                chk("rst_bus_addr",  bus_addr,       32'd0);
                chk("rst_bus_wdata", bus_wdata,      32'd0);
                chk("rst_wbuf_full", 32'(wbuf_full), 32'd0);
                chk("rst_bus_err",   32'(bus_err),   32'd0);
                chk("rst_mem_stall", 32'(mem_stall), 32'd0);
                chk("rst_mem_din",   mem_din,        32'd0);
                m_buf_v    = 1'b0;
                m_txn      = 1'b0;
                m_rd_ready = 1'b0;
                m_rdata    = '0;
                m_err      = 1'b0;
                m_age      = 0;
            end else begin
                is_st = mem_wen;
                is_ld = mem_ren & ~mem_wen;
                hit   = is_ld && m_buf_v && (m_buf_a == mem_addr[31:2]);
                acc   = is_st && !m_buf_v && !m_txn && !m_rd_ready;
                if (m_rd_ready)  e_stall = 1'b0;
                else if (is_st)  e_stall = !acc;
                else if (is_ld)  e_stall = !hit;
                else             e_stall = 1'b0;
                chk("mem_stall", 32'(mem_stall), 32'(e_stall));
                chk("mem_din",   mem_din, hit ? m_buf_d : m_rdata);
                chk("bus_req",   32'(bus_req), 32'(m_txn));
                chk("wbuf_full", 32'(wbuf_full), 32'(m_buf_v));
                chk("bus_err",   32'(bus_err), 32'(m_err));
                if (m_txn) begin
                    chk("bus_we",   32'(bus_we), 32'(m_txn_we));
                    chk("bus_addr", bus_addr, m_txn_a);
                    if (m_txn_we) chk("bus_wdata", bus_wdata, m_txn_d);
                end
                m_err = 1'b0;
                nrr   = 1'b0;
                if (m_txn) begin
                    if (bus_ack) begin
                        if (m_txn_we) m_buf_v = 1'b0;
                        else begin
                            m_rdata = smem[m_txn_a[7:2]];
                            nrr     = 1'b1;
                        end
                        m_txn = 1'b0;
                    end else begin
                        m_age++;
                        if (m_age >= TIMEOUT) begin
                            m_err = 1'b1;
                            m_txn = 1'b0;
                            if (m_txn_we) m_buf_v = 1'b0;
                            else begin
                                m_rdata = 32'hDEADBEEF;
                                nrr     = 1'b1;
                            end
                        end
                    end
                end else if (!m_rd_ready) begin
                    if (acc) begin
                        m_buf_v = 1'b1;
                        m_buf_a = mem_addr[31:2];
                        m_buf_d = mem_dout;
                        model_launch(1'b1, mem_addr, mem_dout);
                    end else if (is_ld && !hit && !m_buf_v) begin
                        model_launch(1'b0, mem_addr, 32'd0);
                    end
                end
                m_rd_ready = nrr;
            end
        end
    endtask

    // One core access: present it, hold while stalled, return stall count and data.
    task automatic core_op(input logic ren, input logic wen, input logic [31:0] addr,
                           input logic [31:0] data, output int stalls, output logic [31:0] din);
        bit done;
        mem_ren  = ren;
        mem_wen  = wen;
        mem_addr = addr;
        mem_dout = data;
        stalls   = 0;
        din      = '0;
        done     = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (!mem_stall) begin
                din  = mem_din;
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL core_op_wait stalls=%0d limit=200 addr=%h", stalls, addr);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        mem_ren = 1'b0;
        mem_wen = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    int          st;
    logic [31:0] dd;
    int          n0;
    int          r0;
    int          e0;

    initial begin
        rst      = 1'b0;
        mem_ren  = 1'b0;
        mem_wen  = 1'b0;
        mem_addr = '0;
        mem_dout = '0;
        fork
            compare_loop();
        join_none
        idle(3);
        rst = 1'b1;
        idle(2);

        // Minimum-latency load
        ack_delay = 0;
        core_op(1'b1, 1'b0, 32'h10, 32'h0, st, dd);
        chk("load_min_stalls", 32'(st), 32'd2);
        chk("load_min_data",   dd,      32'h12345678);
        idle(2);

        // Posted store then forwarded load
        ack_delay = 3;
        n0 = wlog_a.size();
        r0 = rd_acks;
        core_op(1'b0, 1'b1, 32'h20, 32'hAA, st, dd);
        chk("post_store_stalls", 32'(st), 32'd0);
        core_op(1'b1, 1'b0, 32'h20, 32'h0, st, dd);
        chk("fwd_load_stalls", 32'(st), 32'd0);
        chk("fwd_load_data",   dd,      32'hAA);
        idle(8);
        chk("fwd_bus_writes", 32'(wlog_a.size() - n0), 32'd1);
        chk("fwd_bus_reads",  32'(rd_acks - r0),       32'd0);

        // Back-to-back stores with delayed ack
        n0 = wlog_a.size();
        core_op(1'b0, 1'b1, 32'h30, 32'h111, st, dd);
        chk("b2b_first_stalls", 32'(st), 32'd0);
        core_op(1'b0, 1'b1, 32'h34, 32'h222, st, dd);
        chk("b2b_second_stalls", 32'(st), 32'd4);
        idle(8);
        chk("b2b_write_count", 32'(wlog_a.size() - n0), 32'd2);
        chk("b2b_first_addr",  wlog_a[n0],     32'h30);
        chk("b2b_second_addr", wlog_a[n0 + 1], 32'h34);
        chk("b2b_second_data", wlog_d[n0 + 1], 32'h222);

        // Load and store both requested: a store to the word address
        ack_delay = 1;
        core_op(1'b1, 1'b1, 32'h23, 32'h5A5A0001, st, dd);
        chk("both_req_stalls", 32'(st), 32'd0);
        idle(5);
        chk("both_req_addr", wlog_a[$], 32'h20);
        chk("both_req_data", wlog_d[$], 32'h5A5A0001);

        // Read timeout
        ack_delay = 255;
        e0 = err_cnt;
        core_op(1'b1, 1'b0, 32'h40, 32'h0, st, dd);
        chk("rd_tmo_stalls", 32'(st), 32'd65);
        chk("rd_tmo_data",   dd,      32'hDEADBEEF);
        idle(3);
        chk("rd_tmo_err_pulses", 32'(err_cnt - e0), 32'd1);

        // Ack on the last permitted cycle completes normally
        ack_delay = TIMEOUT - 1;
        e0 = err_cnt;
        core_op(1'b1, 1'b0, 32'h44, 32'h0, st, dd);
        chk("rd_edge_stalls", 32'(st), 32'd65);
        chk("rd_edge_data",   dd,      32'hC0DE0011);
        idle(3);
        chk("rd_edge_err_pulses", 32'(err_cnt - e0), 32'd0);

        // Write timeout discards the entry
        ack_delay = TIMEOUT;
        e0 = err_cnt;
        core_op(1'b0, 1'b1, 32'h50, 32'h777, st, dd);
        chk("wr_tmo_stalls", 32'(st), 32'd0);
        idle(70);
        chk("wr_tmo_wbuf_full",  32'(wbuf_full),    32'd0);
        chk("wr_tmo_err_pulses", 32'(err_cnt - e0), 32'd1);
        ack_delay = 0;
        core_op(1'b1, 1'b0, 32'h50, 32'h0, st, dd);
        chk("wr_tmo_readback", dd, 32'hC0DE0014);
        idle(2);

        // Reset in the middle of a read, followed by a stray ack
        ack_delay = 255;
        e0 = err_cnt;
        mem_ren  = 1'b1;
        mem_addr = 32'h48;
        idle(3);
        chk("mid_rd_req_active", 32'(bus_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rd_rst_req",   32'(bus_req),   32'd0);
        chk("mid_rd_rst_stall", 32'(mem_stall), 32'd0);
        mem_ren = 1'b0;
        idle(1);
        stray_ack = 1'b1;
        idle(1);
        rst = 1'b1;
        idle(2);
        stray_ack = 1'b0;
        idle(2);
        chk("stray_ack_req",   32'(bus_req),      32'd0);
        chk("stray_ack_wbuf",  32'(wbuf_full),    32'd0);
        chk("stray_ack_err",   32'(err_cnt - e0), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int          k;
            int          op;
            logic [31:0] a;
            k = $urandom_range(0, 49);
            if (k == 0)      ack_delay = TIMEOUT;
            else if (k == 1) ack_delay = TIMEOUT - 1;
            else             ack_delay = $urandom_range(0, 4);
            op = $urandom_range(0, 3);
            a  = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            core_op((op == 1) || (op == 3), (op >= 2), a, $urandom, st, dd);
        end
        idle(TIMEOUT + 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
